ws_pe_db: RTL and testbench

WS_PE_DB -- requirements
Module: ws_pe_db

---
 rtl/ws_pe_db.sv | 215 +++++++++++++++++++++
 tb/tb_ws_pe_db.sv | 227 ++++++++++++++++++++++
 2 files changed

// File: rtl/ws_pe_db.sv
// ws_pe_db: weight-stationary MAC processing element with double-buffered weight.
//   Latency: one cycle from a valid fmap_in/psum_in to psum_out/fmap_out.
//   Backpressure: none. The valid bit flows east and south with the data. Weight
//   preload and swap run in parallel with computation and never stall it.
//
// Ports:
//   clk, rst                    rising-edge clock; asynchronous active-high reset
//   fmap_in, fmap_valid_in      feature word from the west; valid also qualifies psum_in
//   psum_in                     partial sum from the north
//   kernel_in, kernel_load      weight preload chain input and its capture strobe
//   swap                        promote the shadow weight to the active weight
//   ovf_clr                     clear the sticky overflow flag
//   fmap_out, fmap_valid_out    registered feature word and valid, forwarded east
//   kernel_out                  shadow weight, feeding the next PE's kernel_in
//   psum_out, psum_valid_out    registered accumulate result, forwarded south
//   shadow_full                 the shadow weight has not been swapped in yet
//   ovf                         sticky accumulate-overflow flag

module ws_pe_db #(
  parameter int IN_W   = 16,
  parameter int ACC_W  = 32,
  parameter int SIGNED = 1,
  parameter int SAT    = 1
) (
  input  logic               clk,
  input  logic               rst,
  input  logic [IN_W-1:0]    fmap_in,
  input  logic               fmap_valid_in,
  input  logic [ACC_W-1:0]   psum_in,
  input  logic [IN_W-1:0]    kernel_in,
  input  logic               kernel_load,
  input  logic               swap,
  input  logic               ovf_clr,
  output logic [IN_W-1:0]    fmap_out,
  output logic               fmap_valid_out,
  output logic [IN_W-1:0]    kernel_out,
  output logic [ACC_W-1:0]   psum_out,
  output logic               psum_valid_out,
  output logic               shadow_full,
  output logic               ovf
);

  // The full-width product must fit into the accumulator.
  generate
    if (ACC_W < 2 * IN_W) begin : g_acc_w_check
      $error("ws_pe_db: ACC_W must be at least 2*IN_W");
    end
  endgenerate

  localparam int  PROD_W    = 2 * IN_W;
  localparam int  EXT_W     = ACC_W + 1 - PROD_W;
  localparam bit  IS_SIGNED = (SIGNED != 0);
  localparam bit  IS_SAT    = (SAT != 0);

  // ---------------------------------------------------------------------------
  // Weight buffer state machine
  // ---------------------------------------------------------------------------
  typedef enum logic {
    W_EMPTY = 1'b0,
    W_FULL  = 1'b1
  } wstate_e;

  wstate_e state_q;
  wstate_e state_d;

  logic    swap_en;    // swap accepted this cycle
  logic    shadow_we;  // shadow register captures kernel_in this cycle

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q <= W_EMPTY;
    end else begin
      state_q <= state_d;
    end
  end

  always_comb begin
    state_d = state_q;
    case (state_q)
      W_EMPTY: begin
        if (kernel_load) begin
          state_d = W_FULL;
        end
      end
      W_FULL: begin
        // A swap drains the shadow unless a new weight lands in the same cycle.
        if (swap && !kernel_load) begin
          state_d = W_EMPTY;
        end
      end
      default: state_d = W_EMPTY;
    endcase
  end

  always_comb begin
    swap_en   = 1'b0;
    shadow_we = kernel_load;
    case (state_q)
      W_EMPTY: swap_en = 1'b0;   // nothing to promote; swap is ignored
      W_FULL:  swap_en = swap;
      default: swap_en = 1'b0;
    endcase
  end

  // ---------------------------------------------------------------------------
  // Datapath registers
  // ---------------------------------------------------------------------------
  logic [IN_W-1:0]  shadow_q,  shadow_d;
  logic [IN_W-1:0]  active_q,  active_d;
  logic [IN_W-1:0]  fmap_q,    fmap_d;
  logic             fvld_q,    fvld_d;
  logic [ACC_W-1:0] psum_q,    psum_d;
  logic             pvld_q,    pvld_d;
  logic             ovf_q,     ovf_d;

  // ---------------------------------------------------------------------------
  // Multiply-accumulate
  // ---------------------------------------------------------------------------
  logic [PROD_W-1:0] op_a;
  logic [PROD_W-1:0] op_b;
  logic [PROD_W-1:0] prod;
  logic [ACC_W:0]    prod_x;
  logic [ACC_W:0]    psum_x;
  logic [ACC_W:0]    sum;
  logic              ovf_raw;
  logic [ACC_W-1:0]  sat_val;
  logic [ACC_W-1:0]  mac_res;

  always_comb begin
    // Operands are pre-extended to the product width, so the low PROD_W bits
    // of an unsigned multiply are the correct two's-complement product too.
    op_a   = {{IN_W{IS_SIGNED & fmap_in[IN_W-1]}}, fmap_in};
    op_b   = {{IN_W{IS_SIGNED & active_q[IN_W-1]}}, active_q};
    prod   = op_a * op_b;

    // One guard bit above ACC_W exposes signed out-of-range results and carry-out.
    prod_x = {{EXT_W{IS_SIGNED & prod[PROD_W-1]}}, prod};
    psum_x = {IS_SIGNED & psum_in[ACC_W-1], psum_in};
    sum    = psum_x + prod_x;

    if (IS_SIGNED) begin
      ovf_raw = sum[ACC_W] ^ sum[ACC_W-1];
      // The guard bit is the sign of the true result, choosing the rail.
      sat_val = sum[ACC_W] ? {1'b1, {(ACC_W-1){1'b0}}} : {1'b0, {(ACC_W-1){1'b1}}};
    end else begin
      ovf_raw = sum[ACC_W];
      sat_val = {ACC_W{1'b1}};
    end

    mac_res = (ovf_raw && IS_SAT) ? sat_val : sum[ACC_W-1:0];
  end

  always_comb begin
    shadow_d = shadow_q;
    active_d = active_q;
    fmap_d   = fmap_q;
    psum_d   = psum_q;
    fvld_d   = fmap_valid_in;
    pvld_d   = fmap_valid_in;
    ovf_d    = ovf_q;

    // Uses the pre-update shadow, so a simultaneous load and swap promotes
    // the old weight and keeps the new one in the shadow.
    if (swap_en) begin
      active_d = shadow_q;
    end
    if (shadow_we) begin
      shadow_d = kernel_in;
    end

    if (fmap_valid_in) begin
      fmap_d = fmap_in;
      psum_d = mac_res;
    end

    // Set has priority over clear.
    if (fmap_valid_in && ovf_raw) begin
      ovf_d = 1'b1;
    end else if (ovf_clr) begin
      ovf_d = 1'b0;
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      shadow_q <= '0;
      active_q <= '0;
      fmap_q   <= '0;
      fvld_q   <= 1'b0;
      psum_q   <= '0;
      pvld_q   <= 1'b0;
      ovf_q    <= 1'b0;
    end else begin
      shadow_q <= shadow_d;
      active_q <= active_d;
      fmap_q   <= fmap_d;
      fvld_q   <= fvld_d;
      psum_q   <= psum_d;
      pvld_q   <= pvld_d;
      ovf_q    <= ovf_d;
    end
  end

  // ---------------------------------------------------------------------------
  // Outputs
  // ---------------------------------------------------------------------------
  assign fmap_out       = fmap_q;
  assign fmap_valid_out = fvld_q;
  assign kernel_out     = shadow_q;
  assign psum_out       = psum_q;
  assign psum_valid_out = pvld_q;
  assign shadow_full    = (state_q == W_FULL);
  assign ovf            = ovf_q;

endmodule

// File: tb/tb_ws_pe_db.sv
// tb_ws_pe_db: directed vector bench for ws_pe_db.
//   Three instances share stimulus: signed/saturating, signed/wrapping and
//   unsigned/saturating, so every arithmetic mode is checked on each vector.
module tb_ws_pe_db;

  logic        clk;
  logic        rst;
  logic [15:0] fmap_in;
  logic        fmap_valid_in;
  logic [31:0] psum_in;
  logic [15:0] kernel_in;
  logic        kernel_load;
  logic        swap;
  logic        ovf_clr;

  logic [15:0] s_fmap_out, w_fmap_out, u_fmap_out;
  logic        s_fvld, w_fvld, u_fvld;
  logic [15:0] s_kout, w_kout, u_kout;
  logic [31:0] s_psum, w_psum, u_psum;
  logic        s_pvld, w_pvld, u_pvld;
  logic        s_full, w_full, u_full;
  logic        s_ovf, w_ovf, u_ovf;

  ws_pe_db #(.IN_W(16), .ACC_W(32), .SIGNED(1), .SAT(1)) u_sat (
    .clk(clk), .rst(rst), .fmap_in(fmap_in), .fmap_valid_in(fmap_valid_in),
    .psum_in(psum_in), .kernel_in(kernel_in), .kernel_load(kernel_load),
    .swap(swap), .ovf_clr(ovf_clr), .fmap_out(s_fmap_out), .fmap_valid_out(s_fvld),
    .kernel_out(s_kout), .psum_out(s_psum), .psum_valid_out(s_pvld),
    .shadow_full(s_full), .ovf(s_ovf));

  ws_pe_db #(.IN_W(16), .ACC_W(32), .SIGNED(1), .SAT(0)) u_wrap (
    .clk(clk), .rst(rst), .fmap_in(fmap_in), .fmap_valid_in(fmap_valid_in),
    .psum_in(psum_in), .kernel_in(kernel_in), .kernel_load(kernel_load),
    .swap(swap), .ovf_clr(ovf_clr), .fmap_out(w_fmap_out), .fmap_valid_out(w_fvld),
    .kernel_out(w_kout), .psum_out(w_psum), .psum_valid_out(w_pvld),
    .shadow_full(w_full), .ovf(w_ovf));

  ws_pe_db #(.IN_W(16), .ACC_W(32), .SIGNED(0), .SAT(1)) u_uns (
    .clk(clk), .rst(rst), .fmap_in(fmap_in), .fmap_valid_in(fmap_valid_in),
    .psum_in(psum_in), .kernel_in(kernel_in), .kernel_load(kernel_load),
    .swap(swap), .ovf_clr(ovf_clr), .fmap_out(u_fmap_out), .fmap_valid_out(u_fvld),
    .kernel_out(u_kout), .psum_out(u_psum), .psum_valid_out(u_pvld),
    .shadow_full(u_full), .ovf(u_ovf));

  initial clk = 1'b0;
  always #5 clk = ~clk;

  int n_cmp;
  int n_bad;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
    end
  endtask

  typedef struct {
    logic        ld;
    logic [15:0] kin;
    logic        sw;
    logic        vld;
    logic [15:0] fmap;
    logic [31:0] psum;
    logic        clr;
    logic [31:0] e_psum;   // signed, saturating
    logic [31:0] e_wrap;   // signed, wrapping
    logic [31:0] e_uns;    // unsigned, saturating
    logic [15:0] e_fmap;
    logic [15:0] e_kout;
    logic        e_full;
    logic        e_ovf;    // signed instances
    logic        e_uovf;   // unsigned instance
  } vec_t;

  localparam int NV = 30;
  vec_t vecs[NV];

  function automatic vec_t mk(
    input logic ld, input logic [15:0] kin, input logic sw, input logic vld,
    input logic [15:0] fmap, input logic [31:0] psum, input logic clr,
    input logic [31:0] e_psum, input logic [31:0] e_wrap, input logic [31:0] e_uns,
    input logic [15:0] e_fmap, input logic [15:0] e_kout, input logic e_full,
    input logic e_ovf, input logic e_uovf);
    vec_t v;
    v.ld = ld; v.kin = kin; v.sw = sw; v.vld = vld; v.fmap = fmap; v.psum = psum;
    v.clr = clr; v.e_psum = e_psum; v.e_wrap = e_wrap; v.e_uns = e_uns;
    v.e_fmap = e_fmap; v.e_kout = e_kout; v.e_full = e_full; v.e_ovf = e_ovf;
    v.e_uovf = e_uovf;
    return v;
  endfunction

  task automatic drive_idle();
    kernel_load   = 1'b0;
    kernel_in     = 16'h0;
    swap          = 1'b0;
    fmap_valid_in = 1'b0;
    fmap_in       = 16'h0;
    psum_in       = 32'h0;
    ovf_clr       = 1'b0;
  endtask

  task automatic chk_all_zero(input string tag);
    chk({tag, " psum_out"},  s_psum, 32'h0);
    chk({tag, " psum_vld"},  {31'h0, s_pvld}, 32'h0);
    chk({tag, " fmap_out"},  {16'h0, s_fmap_out}, 32'h0);
    chk({tag, " fmap_vld"},  {31'h0, s_fvld}, 32'h0);
    chk({tag, " kernel_out"}, {16'h0, s_kout}, 32'h0);
    chk({tag, " shadow_full"}, {31'h0, s_full}, 32'h0);
    chk({tag, " ovf"},       {31'h0, s_ovf}, 32'h0);
    chk({tag, " uns ovf"},   {31'h0, u_ovf}, 32'h0);
  endtask

  initial begin
    n_cmp = 0;
    n_bad = 0;

    //             ld kin    sw vld fmap     psum          clr  e_psum        e_wrap        e_uns         e_fmap   kout   full ovf uovf
    vecs[0]  = mk(0, 16'd0, 0, 1, 16'd3,   32'd5,        0, 32'd5,        32'd5,        32'd5,        16'd3,   16'd0, 0, 0, 0);
    vecs[1]  = mk(0, 16'd0, 0, 0, 16'd9,   32'd99,       0, 32'd5,        32'd5,        32'd5,        16'd3,   16'd0, 0, 0, 0);
    vecs[2]  = mk(0, 16'd0, 1, 0, 16'd0,   32'd0,        0, 32'd5,        32'd5,        32'd5,        16'd3,   16'd0, 0, 0, 0);
    vecs[3]  = mk(0, 16'd0, 0, 1, 16'd3,   32'd1,        0, 32'd1,        32'd1,        32'd1,        16'd3,   16'd0, 0, 0, 0);
    vecs[4]  = mk(1, 16'd7, 0, 0, 16'd0,   32'd0,        0, 32'd1,        32'd1,        32'd1,        16'd3,   16'd7, 1, 0, 0);
    vecs[5]  = mk(0, 16'd0, 1, 0, 16'd0,   32'd0,        0, 32'd1,        32'd1,        32'd1,        16'd3,   16'd7, 0, 0, 0);
    vecs[6]  = mk(0, 16'd0, 0, 1, 16'd4,   32'd10,       0, 32'd38,       32'd38,       32'd38,       16'd4,   16'd7, 0, 0, 0);
    vecs[7]  = mk(1, 16'd2, 0, 0, 16'd0,   32'd0,        0, 32'd38,       32'd38,       32'd38,       16'd4,   16'd2, 1, 0, 0);
    vecs[8]  = mk(0, 16'd0, 1, 1, 16'd2,   32'd0,        0, 32'd14,       32'd14,       32'd14,       16'd2,   16'd2, 0, 0, 0);
    vecs[9]  = mk(1, 16'd9, 0, 1, 16'd1,   32'd0,        0, 32'd2,        32'd2,        32'd2,        16'd1,   16'd9, 1, 0, 0);
    vecs[10] = mk(0, 16'd0, 0, 1, 16'd2,   32'd0,        0, 32'd4,        32'd4,        32'd4,        16'd2,   16'd9, 1, 0, 0);
    vecs[11] = mk(0, 16'd0, 0, 1, 16'd3,   32'd0,        0, 32'd6,        32'd6,        32'd6,        16'd3,   16'd9, 1, 0, 0);
    vecs[12] = mk(0, 16'd0, 1, 1, 16'd5,   32'd0,        0, 32'd10,       32'd10,       32'd10,       16'd5,   16'd9, 0, 0, 0);
    vecs[13] = mk(0, 16'd0, 0, 1, 16'd5,   32'd0,        0, 32'd45,       32'd45,       32'd45,       16'd5,   16'd9, 0, 0, 0);
    vecs[14] = mk(1, 16'd3, 0, 0, 16'd0,   32'd0,        0, 32'd45,       32'd45,       32'd45,       16'd5,   16'd3, 1, 0, 0);
    vecs[15] = mk(1, 16'd6, 1, 0, 16'd0,   32'd0,        0, 32'd45,       32'd45,       32'd45,       16'd5,   16'd6, 1, 0, 0);
    vecs[16] = mk(0, 16'd0, 0, 1, 16'd1,   32'd0,        0, 32'd3,        32'd3,        32'd3,        16'd1,   16'd6, 1, 0, 0);
    vecs[17] = mk(1, 16'd8, 0, 0, 16'd0,   32'd0,        0, 32'd3,        32'd3,        32'd3,        16'd1,   16'd8, 1, 0, 0);
    vecs[18] = mk(0, 16'd0, 1, 0, 16'd0,   32'd0,        0, 32'd3,        32'd3,        32'd3,        16'd1,   16'd8, 0, 0, 0);
    vecs[19] = mk(0, 16'd0, 0, 1, 16'd1,   32'd0,        0, 32'd8,        32'd8,        32'd8,        16'd1,   16'd8, 0, 0, 0);
    vecs[20] = mk(1, 16'd1, 0, 0, 16'd0,   32'd0,        0, 32'd8,        32'd8,        32'd8,        16'd1,   16'd1, 1, 0, 0);
    vecs[21] = mk(0, 16'd0, 1, 0, 16'd0,   32'd0,        0, 32'd8,        32'd8,        32'd8,        16'd1,   16'd1, 0, 0, 0);
    vecs[22] = mk(0, 16'd0, 0, 1, 16'h0100, 32'h7FFFFFF0, 0, 32'h7FFFFFFF, 32'h800000F0, 32'h800000F0, 16'h0100, 16'd1, 0, 1, 0);
    vecs[23] = mk(0, 16'd0, 0, 0, 16'd0,   32'd0,        0, 32'h7FFFFFFF, 32'h800000F0, 32'h800000F0, 16'h0100, 16'd1, 0, 1, 0);
    vecs[24] = mk(0, 16'd0, 0, 0, 16'd0,   32'd0,        1, 32'h7FFFFFFF, 32'h800000F0, 32'h800000F0, 16'h0100, 16'd1, 0, 0, 0);
    vecs[25] = mk(0, 16'd0, 0, 1, 16'h0100, 32'h7FFFFFF0, 1, 32'h7FFFFFFF, 32'h800000F0, 32'h800000F0, 16'h0100, 16'd1, 0, 1, 0);
    vecs[26] = mk(0, 16'd0, 0, 0, 16'd0,   32'd0,        1, 32'h7FFFFFFF, 32'h800000F0, 32'h800000F0, 16'h0100, 16'd1, 0, 0, 0);
    vecs[27] = mk(0, 16'd0, 0, 1, 16'hFF00, 32'h80000010, 0, 32'h80000000, 32'h7FFFFF10, 32'h8000FF10, 16'hFF00, 16'd1, 0, 1, 0);
    vecs[28] = mk(0, 16'd0, 0, 1, 16'hFFFF, 32'h00000005, 1, 32'd4,        32'd4,        32'h00010004, 16'hFFFF, 16'd1, 0, 0, 0);
    vecs[29] = mk(0, 16'd0, 0, 1, 16'h0100, 32'hFFFFFFF0, 0, 32'h000000F0, 32'h000000F0, 32'hFFFFFFFF, 16'h0100, 16'd1, 0, 0, 1);

    // Reset state is visible before any clock edge.
    drive_idle();
    rst = 1'b1;
    #2;
    chk_all_zero("reset");

    @(negedge clk);
    rst = 1'b0;

    for (int i = 0; i < NV; i++) begin
      kernel_load   = vecs[i].ld;
      kernel_in     = vecs[i].kin;
      swap          = vecs[i].sw;
      fmap_valid_in = vecs[i].vld;
      fmap_in       = vecs[i].fmap;
      psum_in       = vecs[i].psum;
      ovf_clr       = vecs[i].clr;
      @(negedge clk);
      chk($sformatf("row%0d psum_out", i),    s_psum, vecs[i].e_psum);
      chk($sformatf("row%0d wrap psum_out", i), w_psum, vecs[i].e_wrap);
      chk($sformatf("row%0d uns psum_out", i),  u_psum, vecs[i].e_uns);
      chk($sformatf("row%0d psum_vld", i),    {31'h0, s_pvld}, {31'h0, vecs[i].vld});
      chk($sformatf("row%0d fmap_vld", i),    {31'h0, s_fvld}, {31'h0, vecs[i].vld});
      chk($sformatf("row%0d fmap_out", i),    {16'h0, s_fmap_out}, {16'h0, vecs[i].e_fmap});
      chk($sformatf("row%0d kernel_out", i),  {16'h0, s_kout}, {16'h0, vecs[i].e_kout});
      chk($sformatf("row%0d shadow_full", i), {31'h0, s_full}, {31'h0, vecs[i].e_full});
      chk($sformatf("row%0d ovf", i),         {31'h0, s_ovf}, {31'h0, vecs[i].e_ovf});
      chk($sformatf("row%0d wrap ovf", i),    {31'h0, w_ovf}, {31'h0, vecs[i].e_ovf});
      chk($sformatf("row%0d uns ovf", i),     {31'h0, u_ovf}, {31'h0, vecs[i].e_uovf});
    end

    // Asynchronous reset mid-cycle during a valid stream, with a weight
    // pending in the shadow and an overflow just raised.
    drive_idle();
    kernel_load = 1'b1;
    kernel_in   = 16'd5;
    @(negedge clk);
    kernel_load = 1'b0;
    swap        = 1'b1;
    @(negedge clk);
    swap          = 1'b0;
    kernel_load   = 1'b1;
    kernel_in     = 16'd11;
    fmap_valid_in = 1'b1;
    fmap_in       = 16'h7000;
    psum_in       = 32'h7FFFFFF0;
    @(negedge clk);
    chk("pre-reset ovf", {31'h0, s_ovf}, 32'h1);
    chk("pre-reset shadow_full", {31'h0, s_full}, 32'h1);
    fmap_in = 16'd2;
    psum_in = 32'd1;
    @(posedge clk);
    #2;
    rst = 1'b1;
    #1;
    chk_all_zero("async reset");

    @(negedge clk);
    drive_idle();
    @(negedge clk);
    rst = 1'b0;
    fmap_valid_in = 1'b1;
    fmap_in       = 16'd4;
    psum_in       = 32'd9;
    @(negedge clk);
    chk("post-reset psum_out", s_psum, 32'd9);
    chk("post-reset psum_vld", {31'h0, s_pvld}, 32'h1);
    chk("post-reset fmap_out", {16'h0, s_fmap_out}, 32'd4);
    chk("post-reset shadow_full", {31'h0, s_full}, 32'h0);
    drive_idle();
    @(negedge clk);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
